// File: rtl/video_frame_sequencer.sv
// video_frame_sequencer
//   Runs a sequence of frames through source -> pixel filter -> writer.
//   Each frame: pulse src_begin, wait for the source to report done and for
//   the sink vsync to fall, optionally idle for an inter-frame gap, repeat
//   for frame_num frames (0 = run until abort or timeout). Every frame is
//   guarded by a watchdog.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         1-cycle request to begin a sequence (ignored while busy)
//   frame_num     frames to run, sampled on accepted start (0 = continuous)
//   abort         ends the sequence from any non-idle state
//   src_begin     begin pulse to the video source (BEGIN_PULSE_W cycles)
//   src_done      source finished the current frame (level or pulse)
//   post_vsync    pipeline output vsync; 1->0 edge marks sink frame end
//   busy          sequence in progress
//   frames_done   frames completed in the current/last sequence (wraps)
//   seq_done      1-cycle pulse when a sequence ends
//   timeout_err   sticky watchdog flag, cleared by the next accepted start
//
// Optional build macro VIDEO_FRAME_SEQ_STATS_EN adds:
//   last_frame_cycles  cycles from BEGIN entry to WAIT exit (inclusive) of
//                      the last completed frame
//   max_frame_cycles   maximum of that count over the sequence
module video_frame_sequencer #(
  parameter int unsigned BEGIN_PULSE_W  = 5,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter int unsigned TMO_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] frame_num,
  input  logic                   abort,
  output logic                   src_begin,
  input  logic                   src_done,
  input  logic                   post_vsync,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   seq_done,
  output logic                   timeout_err
`ifdef VIDEO_FRAME_SEQ_STATS_EN
  ,
  output logic [TMO_W-1:0]       last_frame_cycles,
  output logic [TMO_W-1:0]       max_frame_cycles
`endif
);

  localparam int unsigned PULSE_CW = (BEGIN_PULSE_W > 1) ? $clog2(BEGIN_PULSE_W) : 1;
  localparam int unsigned GAP_CW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PULSE_CW-1:0] PULSE_LAST =
    PULSE_CW'((BEGIN_PULSE_W > 0) ? BEGIN_PULSE_W - 1 : 0);
  localparam logic [GAP_CW-1:0] GAP_LAST =
    GAP_CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_WAIT,
    S_GAP,
    S_END
  } state_t;

  state_t state, next_state;

  logic [FRAME_CNT_W-1:0] frame_target;
  logic [FRAME_CNT_W-1:0] frames_inc;
  logic [PULSE_CW-1:0]    pulse_cnt;
  logic [GAP_CW-1:0]      gap_cnt;
  logic [TMO_W-1:0]       wd;
  logic [TMO_W-1:0]       wd_inc;
  logic                   vsync_d;
  logic                   vs_fall;
  logic                   src_seen;
  logic                   sink_seen;
  logic                   frame_ok;
  logic                   wd_expired;
  logic                   last_frame;
  logic                   in_frame;
  logic                   accept;
  logic                   frame_exit;
  logic                   timeout_hit;
  logic                   begin_entry;

  assign vs_fall    = vsync_d & ~post_vsync;
  assign frame_ok   = src_seen & sink_seen;
  assign wd_expired = (wd == TMO_LAST);
  assign frames_inc = frames_done + FRAME_CNT_W'(1);
  assign wd_inc     = wd + TMO_W'(1);
  assign last_frame = (frame_target != '0) && (frames_inc == frame_target);
  assign in_frame   = (state == S_BEGIN) || (state == S_WAIT);

  // Any transition into BEGIN (from IDLE, GAP or straight from WAIT when
  // there is no gap) starts a fresh frame: flags, pulse timer and watchdog.
  assign begin_entry = (next_state == S_BEGIN) && (state != S_BEGIN);

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    frame_exit  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = S_BEGIN;
          accept     = 1'b1;
        end
      end
      S_BEGIN: begin
        if (abort) begin
          next_state = S_END;
        end else if (wd_expired) begin
          next_state  = S_END;
          timeout_hit = 1'b1;
        end else if (pulse_cnt == PULSE_LAST) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A frame that completes on the watchdog's final cycle still counts.
        if (abort) begin
          next_state = S_END;
        end else if (frame_ok) begin
          frame_exit = 1'b1;
          if (last_frame)
            next_state = S_END;
          else if (GAP_CYCLES == 0)
            next_state = S_BEGIN;
          else
            next_state = S_GAP;
        end else if (wd_expired) begin
          next_state  = S_END;
          timeout_hit = 1'b1;
        end
      end
      S_GAP: begin
        if (abort)
          next_state = S_END;
        else if (gap_cnt == GAP_LAST)
          next_state = S_BEGIN;
      end
      S_END:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      src_begin    <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
      frames_done  <= '0;
      frame_target <= '0;
      pulse_cnt    <= '0;
      gap_cnt      <= '0;
      wd           <= '0;
      vsync_d      <= 1'b0;
      src_seen     <= 1'b0;
      sink_seen    <= 1'b0;
    end else begin
      state     <= next_state;
      // Outputs registered from next_state so they track the state register.
      src_begin <= (next_state == S_BEGIN);
      busy      <= (next_state != S_IDLE);
      // Pulse lands in the cycle after END, i.e. two cycles after the event.
      seq_done  <= (state == S_END);
      vsync_d   <= post_vsync;

      if (accept) begin
        frame_target <= frame_num;
        frames_done  <= '0;
        timeout_err  <= 1'b0;
      end else begin
        if (frame_exit)
          frames_done <= frames_inc;
        if (timeout_hit)
          timeout_err <= 1'b1;
      end

      if (begin_entry) begin
        pulse_cnt <= '0;
        wd        <= '0;
        src_seen  <= 1'b0;
        sink_seen <= 1'b0;
      end else begin
        if (state == S_BEGIN)
          pulse_cnt <= pulse_cnt + PULSE_CW'(1);
        if (in_frame) begin
          wd <= wd_inc;
          if (src_done)
            src_seen <= 1'b1;
          if (vs_fall)
            sink_seen <= 1'b1;
        end
      end

      if (state == S_GAP)
        gap_cnt <= gap_cnt + GAP_CW'(1);
      else
        gap_cnt <= '0;
    end
  end

`ifdef VIDEO_FRAME_SEQ_STATS_EN
  // wd holds cycles already spent in the frame; the exit cycle adds one.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_frame_cycles <= '0;
      max_frame_cycles  <= '0;
    end else if (accept) begin
      last_frame_cycles <= '0;
      max_frame_cycles  <= '0;
    end else if (frame_exit) begin
      last_frame_cycles <= wd_inc;
      if (wd_inc > max_frame_cycles)
        max_frame_cycles <= wd_inc;
    end
  end
`endif

endmodule
